// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the core-side load/store path and dmem_ctrl.
// Member names keep the controller's _i/_o port naming so existing hookups map one-to-one.
interface dmem_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  mask_i;
    logic [31:0] rdata_o;
    logic        valid_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, mask_i,
        input  rdata_o, valid_o, err_o, stall_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mask_i,
        output rdata_o, valid_o, err_o, stall_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-masked word memory with a fixed number of wait states per access.
// Operations are served one at a time: IDLE -> (WAIT) -> RESP, with a one-cycle valid pulse.
module dmem_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [31:2]         addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          mask_q;
    logic [31:0]         rdata_q;
    logic                valid_q;
    logic                err_q;

    logic [31:0]         mem_q [0:(2**ADDR_W)-1];

    logic                acc_we;
    logic [31:2]         acc_addr;
    logic [31:0]         acc_wdata;
    logic [3:0]          acc_mask;
    logic                acc_oor;
    logic [ADDR_W-1:0]   acc_idx;
    logic                do_access;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^bus.addr_i[1:0];

    // Zero wait states: the access happens on the accept edge, so operands come straight off the bus.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_mask  = mask_q;
        do_access = 1'b0;
        if (WAIT_CYCLES == 0) begin
            acc_we    = bus.we_i;
            acc_addr  = bus.addr_i[31:2];
            acc_wdata = bus.wdata_i;
            acc_mask  = bus.mask_i;
            do_access = (state_q == IDLE) && bus.req_i;
        end else begin
            do_access = (state_q == WAIT) && (cnt_q == 4'd0);
        end
        acc_oor = |acc_addr[31:ADDR_W+2];
        acc_idx = acc_addr[ADDR_W+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i[31:2];
                        wdata_q <= bus.wdata_i;
                        mask_q  <= bus.mask_i;
                        cnt_q   <= CNT_INIT;
                        if (WAIT_CYCLES != 0) begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            if (do_access) begin
                state_q <= RESP;
                valid_q <= 1'b1;
                err_q   <= acc_oor;
                if (acc_oor) begin
                    rdata_q <= '0;
                end else if (!acc_we) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    // Array is deliberately not reset; reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_we && !acc_oor) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (acc_mask[n]) begin
                    mem_q[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
                end
            end
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;
    assign bus.stall_o = ((state_q == IDLE) && bus.req_i) || (state_q == WAIT);

endmodule
